// File: rtl/tmr_cap_flt.sv
// Capture-pin conditioner: synchroniser, optional inversion, tick-based sampling and an
// N-consecutive-sample glitch filter driving the timer capture channel.
module tmr_cap_flt #(
   parameter int STAGE     = 2,
   parameter int DIV_WIDTH = 16,
   parameter int FLT_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 inv_i,
   input  logic [DIV_WIDTH-1:0] smpl_div_i,
   input  logic [FLT_WIDTH-1:0] flt_len_i,
   input  logic                 glitch_clr_i,
   input  logic                 capch_i,
   output logic                 capch_o,
   output logic                 rise_o,
   output logic                 fall_o,
   output logic [7:0]           glitch_cnt_o
);

   typedef enum logic {
      STABLE,
      PEND
   } state_e;

   state_e                 state_q, state_d;
   logic [STAGE-1:0]       sync_q;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [FLT_WIDTH-1:0]   run_q, run_d;
   logic                   cap_q, cap_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [7:0]             glitch_q, glitch_d;

   logic                   smp;
   logic                   tick;
   logic                   accept;
   logic [FLT_WIDTH-1:0]   flen;
   logic [FLT_WIDTH:0]     runInc;

   assign smp    = sync_q[STAGE-1] ^ inv_i;
   assign tick   = en_i && (div_q >= smpl_div_i);
   assign flen   = (flt_len_i == '0) ? {{(FLT_WIDTH-1){1'b0}}, 1'b1} : flt_len_i;
   assign runInc = {1'b0, run_q} + {{FLT_WIDTH{1'b0}}, 1'b1};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGE-2:0], capch_i};
      end
   end

   always_comb begin
      div_d = div_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      if (!en_i || tick) begin
         div_d = '0;
      end
   end

   // Filter decisions are taken only on sample ticks; disabling parks the FSM but keeps the level.
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      cap_d    = cap_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      glitch_d = glitch_q;
      accept   = 1'b0;
      if (!en_i) begin
         state_d = STABLE;
         run_d   = '0;
      end else if (tick) begin
         case (state_q)
            STABLE: begin
               if (smp != cap_q) begin
                  if (flen == {{(FLT_WIDTH-1){1'b0}}, 1'b1}) begin
                     accept = 1'b1;
                  end else begin
                     run_d   = {{(FLT_WIDTH-1){1'b0}}, 1'b1};
                     state_d = PEND;
                  end
               end
            end
            PEND: begin
               if (smp == cap_q) begin
                  run_d   = '0;
                  state_d = STABLE;
                  if (glitch_q != 8'hFF) begin
                     glitch_d = glitch_q + 8'd1;
                  end
               end else if (runInc >= {1'b0, flen}) begin
                  accept = 1'b1;
               end else begin
                  run_d = runInc[FLT_WIDTH-1:0];
               end
            end
            default: state_d = STABLE;
         endcase
      end
      if (accept) begin
         cap_d   = ~cap_q;
         rise_d  = ~cap_q;
         fall_d  = cap_q;
         run_d   = '0;
         state_d = STABLE;
      end
      if (glitch_clr_i) begin
         glitch_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= STABLE;
         div_q    <= '0;
         run_q    <= '0;
         cap_q    <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         run_q    <= run_d;
         cap_q    <= cap_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
      end
   end

   assign capch_o      = cap_q;
   assign rise_o       = rise_q;
   assign fall_o       = fall_q;
   assign glitch_cnt_o = glitch_q;

endmodule
